// File: rtl/fetch_unit.sv
// Instruction-fetch front end: issues word-aligned fetches over a valid/ready channel,
// buffers in-order responses as {pc, instr} and discards wrong-path data on redirect.
module fetch_unit #(
  parameter int PC_W = 9,
  parameter int INS_W = 32,
  parameter int FIFO_DEPTH = 2,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             redirect_valid,
  input  logic [PC_W-1:0]  redirect_pc,
  output logic             imem_req_valid,
  output logic [PC_W-1:0]  imem_req_addr,
  input  logic             imem_req_ready,
  input  logic             imem_resp_valid,
  input  logic [INS_W-1:0] imem_resp_data,
  output logic             if_valid,
  output logic [PC_W-1:0]  if_pc,
  output logic [INS_W-1:0] if_instr
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int OCC_W = CNT_W + 1;

  logic [PC_W-1:0]  r_fetchPc;
  logic [PC_W-1:0]  r_respPc;
  logic [CNT_W-1:0] r_outstanding;
  logic [CNT_W-1:0] r_dropCnt;
  logic [CNT_W-1:0] r_count;
  logic [PTR_W-1:0] r_wrPtr;
  logic [PTR_W-1:0] r_rdPtr;
  logic [PC_W-1:0]  r_fifoPc    [FIFO_DEPTH];
  logic [INS_W-1:0] r_fifoInstr [FIFO_DEPTH];

  logic [OCC_W-1:0] w_occupancy;
  logic             w_reqValid;
  logic             w_reqFire;
  logic             w_dropResp;
  logic             w_push;
  logic             w_headValid;
  logic             w_pop;
  logic [PC_W-1:0]  w_redirectPc;
  logic [CNT_W-1:0] w_dropLive;
  logic [CNT_W-1:0] w_outstandingNext;

  // Occupancy counts buffered entries plus in-flight responses that will be kept,
  // so every accepted response is guaranteed a FIFO slot.
  assign w_occupancy = OCC_W'(r_count) + OCC_W'(r_outstanding) - OCC_W'(r_dropCnt);
  assign w_reqValid  = !reset && !redirect_valid
                       && (r_outstanding < CNT_W'(FIFO_DEPTH))
                       && (w_occupancy < OCC_W'(FIFO_DEPTH));
  assign w_reqFire   = w_reqValid && imem_req_ready;

  assign w_dropResp   = imem_resp_valid && (r_dropCnt != '0);
  assign w_push       = imem_resp_valid && (r_dropCnt == '0) && !redirect_valid;
  assign w_headValid  = (r_count != '0);
  assign w_pop        = w_headValid && !stall && !redirect_valid;
  assign w_redirectPc = redirect_pc & ~PC_W'(3);

  assign w_dropLive        = r_outstanding - CNT_W'(imem_resp_valid);
  assign w_outstandingNext = r_outstanding + CNT_W'(w_reqFire) - CNT_W'(imem_resp_valid);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_fetchPc     <= RESET_PC;
      r_respPc      <= RESET_PC;
      r_outstanding <= '0;
      r_dropCnt     <= '0;
      r_count       <= '0;
      r_wrPtr       <= '0;
      r_rdPtr       <= '0;
    end else begin
      r_outstanding <= w_outstandingNext;
      if (redirect_valid) begin
        r_fetchPc <= w_redirectPc;
        r_respPc  <= w_redirectPc;
        r_dropCnt <= w_dropLive;
        r_count   <= '0;
        r_wrPtr   <= '0;
        r_rdPtr   <= '0;
      end else begin
        if (w_reqFire) begin
          r_fetchPc <= r_fetchPc + PC_W'(4);
        end
        if (w_dropResp) begin
          r_dropCnt <= r_dropCnt - CNT_W'(1);
        end
        if (w_push) begin
          r_respPc <= r_respPc + PC_W'(4);
          r_wrPtr  <= r_wrPtr + PTR_W'(1);
        end
        if (w_pop) begin
          r_rdPtr <= r_rdPtr + PTR_W'(1);
        end
        r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
      end
    end
  end

  // Storage needs no reset: the head is only presented while the count is non-zero.
  always_ff @(posedge clk) begin
    if (w_push && !reset) begin
      r_fifoPc[r_wrPtr]    <= r_respPc;
      r_fifoInstr[r_wrPtr] <= imem_resp_data;
    end
  end

  assign imem_req_valid = w_reqValid;
  assign imem_req_addr  = r_fetchPc;
  assign if_valid       = !reset && w_headValid;
  assign if_pc          = if_valid ? r_fifoPc[r_rdPtr] : '0;
  assign if_instr       = if_valid ? r_fifoInstr[r_rdPtr] : '0;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a behavioural in-order instruction memory
// returning 0x00000013 | addr after a configurable number of cycles.
module tb_fetch_unit;

  localparam int PC_W  = 9;
  localparam int INS_W = 32;

  logic             clk;
  logic             reset;
  logic             stall;
  logic             redirect_valid;
  logic [PC_W-1:0]  redirect_pc;
  logic             imem_req_valid;
  logic [PC_W-1:0]  imem_req_addr;
  logic             imem_req_ready;
  logic             imem_resp_valid;
  logic [INS_W-1:0] imem_resp_data;
  logic             if_valid;
  logic [PC_W-1:0]  if_pc;
  logic [INS_W-1:0] if_instr;

  int checkCount = 0;
  int errorCount = 0;

  int              memLat   = 1;
  int              cycleCnt = 0;
  logic [PC_W-1:0] memQAddr[$];
  int              memQDue[$];

  fetch_unit #(
    .PC_W(PC_W),
    .INS_W(INS_W),
    .FIFO_DEPTH(2),
    .RESET_PC('0)
  ) dut (
    .clk(clk),
    .reset(reset),
    .stall(stall),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc),
    .imem_req_valid(imem_req_valid),
    .imem_req_addr(imem_req_addr),
    .imem_req_ready(imem_req_ready),
    .imem_resp_valid(imem_resp_valid),
    .imem_resp_data(imem_resp_data),
    .if_valid(if_valid),
    .if_pc(if_pc),
    .if_instr(if_instr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory: accepted requests are captured mid-cycle, answered memLat cycles later.
  always @(negedge clk) begin
    if (!reset && imem_req_valid && imem_req_ready) begin
      memQAddr.push_back(imem_req_addr);
      memQDue.push_back(cycleCnt + memLat);
    end
  end

  always @(posedge clk) begin
    #2;
    cycleCnt = cycleCnt + 1;
    if (reset) begin
      memQAddr.delete();
      memQDue.delete();
      imem_resp_valid = 1'b0;
      imem_resp_data  = '0;
    end else if (memQDue.size() > 0 && memQDue[0] <= cycleCnt) begin
      imem_resp_valid = 1'b1;
      imem_resp_data  = 32'h13 | 32'(memQAddr[0]);
      void'(memQAddr.pop_front());
      void'(memQDue.pop_front());
    end else begin
      imem_resp_valid = 1'b0;
      imem_resp_data  = '0;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Moves to the next cycle with the given inputs and returns at its falling edge.
  task automatic applyStimulus(input logic rst, input logic stl, input logic rdv,
                               input logic [PC_W-1:0] rdpc, input logic rdy);
    @(posedge clk);
    #1;
    reset          = rst;
    stall          = stl;
    redirect_valid = rdv;
    redirect_pc    = rdpc;
    imem_req_ready = rdy;
    @(negedge clk);
  endtask

  task automatic doReset();
    applyStimulus(1'b1, 1'b0, 1'b0, '0, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b0, '0, 1'b1);
  endtask

  // Waits (bounded) for the head, checks it and consumes it.
  task automatic expectDeliver(input string tag, input logic [PC_W-1:0] pc);
    int waited = 0;
    while (!if_valid && waited < 10) begin
      applyStimulus(1'b0, 1'b0, 1'b0, '0, imem_req_ready);
      waited++;
    end
    checkOutput({tag, "_valid"}, 32'(if_valid), 32'd1);
    checkOutput({tag, "_pc"}, 32'(if_pc), 32'(pc));
    checkOutput({tag, "_instr"}, if_instr, 32'h13 | 32'(pc));
    applyStimulus(1'b0, 1'b0, 1'b0, '0, imem_req_ready);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset           = 1'b1;
    stall           = 1'b0;
    redirect_valid  = 1'b0;
    redirect_pc     = '0;
    imem_req_ready  = 1'b1;
    imem_resp_valid = 1'b0;
    imem_resp_data  = '0;

    // Reset state and cold-start latency
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 1'b0, '0, 1'b1);
    checkOutput("rst_ifValid", 32'(if_valid), 32'd0);
    checkOutput("rst_reqValid", 32'(imem_req_valid), 32'd0);
    checkOutput("rst_ifPc", 32'(if_pc), 32'd0);
    checkOutput("rst_ifInstr", if_instr, 32'd0);

    applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b1);
    checkOutput("t1_c0_reqValid", 32'(imem_req_valid), 32'd1);
    checkOutput("t1_c0_reqAddr", 32'(imem_req_addr), 32'h000);
    checkOutput("t1_c0_ifValid", 32'(if_valid), 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b1);
    checkOutput("t1_c1_reqValid", 32'(imem_req_valid), 32'd1);
    checkOutput("t1_c1_reqAddr", 32'(imem_req_addr), 32'h004);
    checkOutput("t1_c1_ifValid", 32'(if_valid), 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b1);
    checkOutput("t1_c2_ifValid", 32'(if_valid), 32'd1);
    expectDeliver("t1_pc000", 9'h000);
    expectDeliver("t1_pc004", 9'h004);
    expectDeliver("t1_pc008", 9'h008);

    // Stall with a full FIFO holding 0x000 and 0x004
    doReset();
    applyStimulus(1'b0, 1'b1, 1'b0, '0, 1'b1);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 1'b0, '0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      if (i > 0) applyStimulus(1'b0, 1'b1, 1'b0, '0, 1'b1);
      checkOutput("t2_stall_ifValid", 32'(if_valid), 32'd1);
      checkOutput("t2_stall_ifPc", 32'(if_pc), 32'h000);
      checkOutput("t2_stall_reqValid", 32'(imem_req_valid), 32'd0);
    end
    applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b1);
    expectDeliver("t2_pc000", 9'h000);
    expectDeliver("t2_pc004", 9'h004);
    expectDeliver("t2_pc008", 9'h008);

    // Two-cycle memory, redirect to an unaligned target with two fetches in flight
    memLat = 2;
    doReset();
    applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b1, 9'h043, 1'b1);
    checkOutput("t3_redirect_reqValid", 32'(imem_req_valid), 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b1);
    checkOutput("t3_reqValid", 32'(imem_req_valid), 32'd1);
    checkOutput("t3_reqAddr", 32'(imem_req_addr), 32'h040);
    checkOutput("t3_ifValid", 32'(if_valid), 32'd0);
    expectDeliver("t3_pc040", 9'h040);
    expectDeliver("t3_pc044", 9'h044);

    // Redirect in the same cycle the response for 0x010 arrives
    memLat = 1;
    doReset();
    applyStimulus(1'b0, 1'b0, 1'b1, 9'h010, 1'b1);
    checkOutput("t4_r1_reqValid", 32'(imem_req_valid), 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b1);
    checkOutput("t4_reqAddr010", 32'(imem_req_addr), 32'h010);
    applyStimulus(1'b0, 1'b0, 1'b1, 9'h080, 1'b1);
    checkOutput("t4_r2_reqValid", 32'(imem_req_valid), 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b1);
    checkOutput("t4_c0_ifValid", 32'(if_valid), 32'd0);
    checkOutput("t4_reqAddr080", 32'(imem_req_addr), 32'h080);
    applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b1);
    checkOutput("t4_c1_ifValid", 32'(if_valid), 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b1);
    checkOutput("t4_c2_ifValid", 32'(if_valid), 32'd1);
    expectDeliver("t4_pc080", 9'h080);
    expectDeliver("t4_pc084", 9'h084);

    // Address wrap at the top of the PC space
    applyStimulus(1'b0, 1'b0, 1'b1, 9'h1F8, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b1);
    expectDeliver("t5_pc1F8", 9'h1F8);
    expectDeliver("t5_pc1FC", 9'h1FC);
    expectDeliver("t5_pc000", 9'h000);
    expectDeliver("t5_pc004", 9'h004);

    // Back-pressure from the memory, then reset mid-stream
    applyStimulus(1'b0, 1'b0, 1'b1, 9'h020, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      if (i > 0) applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b0);
      checkOutput("t6_hold_reqValid", 32'(imem_req_valid), 32'd1);
      checkOutput("t6_hold_reqAddr", 32'(imem_req_addr), 32'h020);
      checkOutput("t6_hold_ifValid", 32'(if_valid), 32'd0);
    end
    applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b1);
    checkOutput("t6_ready_reqAddr", 32'(imem_req_addr), 32'h020);
    applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b1);
    checkOutput("t6_advance_reqAddr", 32'(imem_req_addr), 32'h024);
    expectDeliver("t6_pc020", 9'h020);
    expectDeliver("t6_pc024", 9'h024);
    applyStimulus(1'b1, 1'b0, 1'b0, '0, 1'b1);
    checkOutput("t6_rst_reqValid", 32'(imem_req_valid), 32'd0);
    applyStimulus(1'b1, 1'b0, 1'b0, '0, 1'b1);
    checkOutput("t6_rst_ifValid", 32'(if_valid), 32'd0);
    checkOutput("t6_rst_ifPc", 32'(if_pc), 32'd0);
    checkOutput("t6_rst_ifInstr", if_instr, 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b1);
    checkOutput("t6_restart_reqValid", 32'(imem_req_valid), 32'd1);
    checkOutput("t6_restart_reqAddr", 32'(imem_req_addr), 32'h000);
    expectDeliver("t6_pc000", 9'h000);
    expectDeliver("t6_pc004", 9'h004);

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
